// File: rtl/out_capture.sv
// Change-triggered trace buffer for the processor out bus; timestamps built only with OUT_CAPTURE_TS_EN.
// Latency: an event sampled at edge N is visible at the FWFT head after edge N.
// Backpressure: the head holds while rd_ready=0; events arriving while full are dropped and flag overflow.
module out_capture #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 8,
  parameter int TS_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH-1:0]       sample,
  input  logic                       sample_en,
  input  logic                       clr_ovf,
  output logic [BIT_WIDTH-1:0]       rd_data,
  output logic [TS_WIDTH-1:0]        rd_ts,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [BIT_WIDTH-1:0] dat;
`ifdef OUT_CAPTURE_TS_EN
    logic [TS_WIDTH-1:0]  ts;
`endif
  } entry_t;

  entry_t               mem [DEPTH];
  entry_t               wr_entry;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count_q;
  logic [BIT_WIDTH-1:0] prev;
  logic                 prev_vld;
  logic                 ovf_q;

  logic evt;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A first enabled sample after reset always counts as a change.
  assign evt  = sample_en && (!prev_vld || (sample != prev));
  assign full = (count_q == CW'(DEPTH));
  // rd_valid comes straight from registered count, so rd_ready never reaches it combinationally.
  assign rd_valid = (count_q != '0);
  assign pop  = rd_valid && rd_ready;
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

`ifdef OUT_CAPTURE_TS_EN
  logic [TS_WIDTH-1:0] ts;

  always_ff @(posedge clk) begin
    if (!rst) ts <= '0;
    else      ts <= ts + TS_WIDTH'(1);
  end

  assign wr_entry = '{dat: sample, ts: ts};
  assign rd_ts    = rd_valid ? mem[rd_ptr].ts : '0;
`else
  assign wr_entry = '{dat: sample};
  assign rd_ts    = '0;
`endif

  assign rd_data  = rd_valid ? mem[rd_ptr].dat : '0;
  assign count    = count_q;
  assign overflow = ovf_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // The detector tracks the bus even when the entry itself is dropped.
      if (evt) begin
        prev     <= sample;
        prev_vld <= 1'b1;
      end
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_out_capture.sv
// Randomised self-checking bench for out_capture against a queue-based trace model.
module tb_out_capture;

  localparam int BW    = 4;
  localparam int DEPTH = 8;
  localparam int TSW   = 12;
  localparam int CW    = $clog2(DEPTH+1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [BW-1:0]  sample = '0;
  logic           sample_en = 1'b0;
  logic           clr_ovf = 1'b0;
  logic           rd_ready = 1'b0;
  logic [BW-1:0]  rd_data;
  logic [TSW-1:0] rd_ts;
  logic           rd_valid;
  logic [CW-1:0]  count;
  logic           overflow;

  out_capture #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst), .sample(sample), .sample_en(sample_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_ts(rd_ts), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dat;
    int ts;
  } trace_t;

  trace_t  mq[$];
  int      m_prev;
  bit      m_seen;
  bit      m_ovf;
  int      m_cycle;
  int      tests = 0;
  int      fails = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model by the trace rules, compare after the edge.
  task automatic step(input int s, input bit en, input bit rdy, input bit clr, input bit rst_n);
    bit chg, popq, dropq;
    sample    = BW'(s);
    sample_en = en;
    rd_ready  = rdy;
    clr_ovf   = clr;
    rst       = rst_n;
    if (!rst_n) begin
      mq.delete();
      m_seen  = 0;
      m_prev  = 0;
      m_ovf   = 0;
      m_cycle = 0;
    end else begin
      chg   = en && (!m_seen || s != m_prev);
      popq  = (mq.size() > 0) && rdy;
      dropq = chg && (mq.size() == DEPTH) && !popq;
      if (popq) void'(mq.pop_front());
      if (chg && !dropq) mq.push_back('{dat: s, ts: m_cycle % (1 << TSW)});
      if (chg) begin
        m_prev = s;
        m_seen = 1;
      end
      if (dropq)    m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_cycle++;
    end
    @(posedge clk);
    #1;
    check("count", count, mq.size());
    check("rd_valid", rd_valid, mq.size() > 0);
    check("overflow", overflow, m_ovf);
    if (mq.size() > 0) begin
      check("head_dat", rd_data, mq[0].dat);
`ifdef OUT_CAPTURE_TS_EN
      check("head_ts", rd_ts, mq[0].ts);
`else
      check("head_ts", rd_ts, 0);
`endif
    end
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  int fib[8] = '{0, 1, 1, 2, 3, 5, 8, 13};
  int cur;
  int budget;

  initial begin
    do_reset();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ts", rd_ts, 0);
    check("rst_count", count, 0);

    // First capture: steady value gives exactly one entry.
    for (int i = 0; i < 6; i++) step(3, 1, 0, 0, 1);
    check("first_count", count, 1);
    check("first_dat", rd_data, 3);

    // Fibonacci trace, the repeated 1 is not captured.
    do_reset();
    for (int i = 0; i < 8; i++) step(fib[i], 1, 0, 0, 1);
    check("fib_count", count, 7);

    // Overflow: ten distinct changes into eight entries.
    do_reset();
    for (int i = 1; i <= 10; i++) step(i, 1, 0, 0, 1);
    check("ovf_set", overflow, 1);
    check("ovf_head", rd_data, 1);
    step(10, 1, 0, 1, 1);
    check("ovf_clr", overflow, 0);
    // Full with a simultaneous push and pop.
    step(12, 1, 1, 0, 1);
    check("fullpp_count", count, 8);
    check("fullpp_ovf", overflow, 0);
    // Drop and clear in the same cycle keeps the flag.
    step(13, 1, 0, 1, 1);
    check("drop_clr_ovf", overflow, 1);

    // Backpressure drain of five entries.
    do_reset();
    for (int i = 0; i < 5; i++) step(i + 4, 1, 0, 0, 1);
    budget = 200;
    while (mq.size() > 0 && budget > 0) begin
      step(8, $urandom_range(0, 2) == 0, $urandom_range(0, 1), 0, 1);
      budget--;
    end
    check("drain_budget", budget > 0, 1);
    check("drain_empty", count, 0);

    // Reset mid-run with four entries, then recapture the same value.
    do_reset();
    for (int i = 0; i < 4; i++) step(i + 6, 1, 0, 0, 1);
    check("mid_count", count, 4);
    step(9, 1, 0, 0, 0);
    check("mid_rst_count", count, 0);
    step(9, 1, 0, 0, 1);
    check("mid_recapture", count, 1);

    // Random mix with repeats, stalls, clears and rare resets.
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) != 0) cur = $urandom_range(0, 15);
      step(cur, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/out_capture.md
# out_capture

Parametrised output-trace buffer for the microprocessor's `out` bus. It is the synthesisable successor to the bench-side monitor. Each time the sampled bus changes value while capture is enabled, it stores the new value and a free-running cycle timestamp in a DEPTH-entry first-word-fall-through FIFO. Entries are drained through a valid/ready read port. It sits beside `top`, on `top`'s `out` bus, and feeds a UART or debug host.

## Interface
Parameters:
- `BIT_WIDTH`, 4: width of the sampled bus; matches `top`'s BIT_WIDTH.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TS_WIDTH`, 12: timestamp counter width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `sample`  in  BIT_WIDTH  monitored bus (processor `out`).
- `sample_en`  in  1  capture enable.
- `clr_ovf`  in  1  clears sticky `overflow`.
- `rd_data`  out  BIT_WIDTH  head entry value.
- `rd_ts`  out  TS_WIDTH  head entry timestamp.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts head.
- `count`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky: an event was dropped.

## Operation
- Timestamp counter `ts`: reset 0; +1 every cycle; wraps modulo 2^TS_WIDTH.
- Change detector: registers `prev` and `prev_vld`.
  - Reset: `prev_vld`=0, `prev`=0.
  - With `sample_en`=1, an event fires when `prev_vld`=0 or `sample`≠`prev`.
  - On an event, `prev`←`sample` and `prev_vld`←1, whether or not the entry is stored.
  - With `sample_en`=0, no events fire and `prev` and `prev_vld` hold.
- Push: an event stores {`sample`, `ts`} at the tail when not full, or when full with a pop in the same cycle.
- Dropped event: when full with no pop, the event is discarded and `overflow`←1.
- `overflow` persistence: holds until reset, or a cycle with `clr_ovf`=1 and no new drop. A drop and `clr_ovf` in the same cycle leaves `overflow`=1.
- Pop: occurs when `rd_valid`&&`rd_ready`; the head advances.
- Idle pops: `rd_ready` while empty has no effect.
- Read port: `rd_data`/`rd_ts` always reflect the head entry (FWFT). They are don't-care while `rd_valid`=0.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Pointers: log2(DEPTH) bits with wrap, plus separate full/empty tracking via `count`.

## Timing
- Reset values: `rd_valid`=0, `count`=0, `overflow`=0, `rd_data`=0, `rd_ts`=0, `ts`=0. The memory contents are not reset.
- Reset mid-operation: all entries discarded; the next enabled sample is treated as a first capture.
- Latency: the event at edge N is visible at the head after edge N. `rd_valid` rises in the cycle following the sampling edge when the FIFO was empty. The stored `rd_ts` equals the `ts` value present before edge N.
- Handshake: the consumer must not see the head change while `rd_valid`=1 and `rd_ready`=0. There is no combinational path from `rd_ready` to `rd_valid`.
- Timestamp wrap: entries are not tagged with wrap information; the host resolves wraps using gaps.

## Configuration
- `OUT_CAPTURE_TS_EN` defined: the timestamp counter and the `ts` field in FIFO storage are built; `rd_ts` behaves as above.
- Macro undefined:
  - The counter and the `ts` storage are removed.
  - `rd_ts` is tied to 0.
  - All other behaviour is identical.

## Test plan
- First capture after reset:
  - Stimulus: release reset, hold `sample`=4'h3 with `sample_en`=1, `rd_ready`=0.
  - Response: exactly one entry (3, ts=0 relative to the first enabled edge); `count`=1; no further entries while `sample` is steady.
- Fibonacci trace:
  - Stimulus: drive 0,1,1,2,3,5,8,13, one value per cycle, `rd_ready`=0.
  - Response: 7 entries 0,1,2,3,5,8,13, consecutive ts except for the held 1 (gap of 2); `rd_valid`=1.
- Overflow:
  - Stimulus: DEPTH=8, 10 distinct changes, `rd_ready`=0.
  - Response: `count`=8; the first 8 values are retained; `overflow`=1.
  - Follow-up: `clr_ovf` pulse gives `overflow`=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, one change with `rd_ready`=1.
  - Response: head popped, new entry stored, `count` stays 8, `overflow` stays 0.
- Backpressure and drain:
  - Stimulus: toggle `rd_ready` randomly over 5 queued entries.
  - Response: head stable while stalled; order and values preserved; `count` reaches 0 with `rd_valid`=0.
- Reset mid-run:
  - Stimulus: assert `rst`=0 for one cycle while `count`=4.
  - Response: `count`=0, `rd_valid`=0, `overflow`=0; the next enabled sample is captured even if equal to the pre-reset value.
